// File: rtl/fifo_stream_reader.sv
// Purpose  : drains a registered-read FIFO port into a valid/ready stream with packet framing.
// Latency  : 2 cycles from fifo_rinc to dout_valid into an empty buffer; 1 word/clk sustained.
// Backpress: dout_ready low holds dout/dout_valid; reads stop once 2 words are held or in flight.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   read enable; low stops new FIFO reads (held words still drain)
//   fifo_rdata           FIFO read data, valid the cycle after fifo_rinc
//   fifo_rempty          FIFO empty flag
//   fifo_rinc            FIFO read strobe (combinational)
//   dout, dout_valid,    output stream, dout_valid/dout held until accepted
//   dout_ready
//   dout_last            final word of a PKT_LEN-word packet, qualified by dout_valid
//   wcnt, pkt_done       only when READER_WCNT_EN is defined: running pop count and a
//                        registered one-cycle pulse after the last word of a packet pops
//
// Optional feature macro: READER_WCNT_EN

module fifo_stream_reader #(
    parameter int DSIZE   = 32,
    parameter int PKT_LEN = 16,
    parameter int CWIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic [DSIZE-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last
`ifdef READER_WCNT_EN
    ,
    output logic [31:0]      wcnt,
    output logic             pkt_done
`endif
);

    localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(PKT_LEN - 1);

    // Two-entry skid storage. head/tail are single-bit indices into it.
    logic [DSIZE-1:0]  buf_q [2];
    logic              head;
    logic              tail;
    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic              inflight;
    logic [CWIDTH-1:0] pkt_cnt;

    logic              pop;
    logic              push;
    logic [2:0]        committed;

    assign pop  = dout_valid & dout_ready;
    // A word requested last cycle lands in fifo_rdata now and is captured this edge.
    assign push = inflight;

    // Slots that will be occupied after this edge if nothing new is requested.
    // pop implies occ >= 1, so the subtraction cannot wrap.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // Never strobe an empty FIFO: it would update rdata with stale contents.
    // rst_n gating keeps the strobe quiet while the whole block is held in reset.
    assign fifo_rinc = rst_n & en & ~fifo_rempty & (committed < 3'd2);

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            head     <= 1'b0;
            tail     <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rinc;
            occ      <= occ_nxt;
            if (push) begin
                buf_q[tail] <= fifo_rdata;
                tail        <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

    // Packet position advances only on accepted words, so gaps in the FIFO
    // stream leave the framing where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (pop) begin
            if (pkt_cnt == LAST_IDX) begin
                pkt_cnt <= '0;
            end else begin
                pkt_cnt <= pkt_cnt + CWIDTH'(1);
            end
        end
    end

    // Output is taken from storage only; fifo_rdata never reaches dout directly.
    assign dout       = buf_q[head];
    assign dout_valid = (occ != 2'd0);
    assign dout_last  = dout_valid & (pkt_cnt == LAST_IDX);

`ifdef READER_WCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt     <= 32'd0;
            pkt_done <= 1'b0;
        end else begin
            if (pop) begin
                wcnt <= wcnt + 32'd1;
            end
            pkt_done <= pop & dout_last;
        end
    end
`endif

endmodule
